// File: rtl/crypto_reg_arbiter_pkg.sv
// Shared definitions for the crypto register-bank arbiter: default sizes,
// FSM state encodings and requester port identifiers.
package crypto_pkg;

   localparam int DATA_W_DEF   = 16;
   localparam int ADDR_W_DEF   = 3;
   localparam int NUM_REGS_DEF = 6;
   localparam int LOCK_MAX_DEF = 32;

   // Arbiter FSM state encodings.
   localparam logic [1:0] ST_IDLE        = 2'd0;
   localparam logic [1:0] ST_LOCKED      = 2'd1;
   localparam logic [1:0] ST_RELOCK_WAIT = 2'd2;

   // Requester identifiers, as stored in last_winner.
   localparam logic PORT_BUS  = 1'b0;
   localparam logic PORT_CORE = 1'b1;

endpackage

// File: rtl/crypto_reg_arbiter_if.sv
// Request/grant bundle between the two requesters (bus and core) and the
// register-bank arbiter.
interface crypto_reg_arbiter_if
   import crypto_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);
   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic              bus_gnt;
   logic [DATA_W-1:0] bus_rdata;
   logic              bus_err;

   logic              core_req;
   logic              core_we;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata;
   logic              core_lock;
   logic              core_gnt;
   logic [DATA_W-1:0] core_rdata;
   logic              core_err;

   logic              lock_active;
   logic              lock_timeout;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata,
      output core_req, core_we, core_addr, core_wdata, core_lock,
      input  bus_gnt, bus_rdata, bus_err,
      input  core_gnt, core_rdata, core_err, lock_active, lock_timeout
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata,
      input  core_req, core_we, core_addr, core_wdata, core_lock,
      output bus_gnt, bus_rdata, bus_err,
      output core_gnt, core_rdata, core_err, lock_active, lock_timeout
   );

endinterface

// File: rtl/crypto_reg_arbiter_lock_timer.sv
// Lock-hold counter: cleared outside a lock, counts while enabled and
// saturates at LOCK_MAX-1, where it flags expiry.
module crypto_lock_timer
   import crypto_pkg::*;
#(
   parameter int LOCK_MAX = LOCK_MAX_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);
   localparam int             CNT_W   = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (enable && (cnt_q != CNT_MAX))
         cnt_d = cnt_q + CNT_W'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign expire = enable && (cnt_q == CNT_MAX);

endmodule

// File: rtl/crypto_reg_arbiter.sv
// Register bank shared between the system bus and the crypto core: one
// transfer per edge, round-robin on ties, optional core lock with timeout.
module crypto_reg_arbiter
   import crypto_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int LOCK_MAX = LOCK_MAX_DEF
) (
   input logic                 clk,
   input logic                 rst,
   crypto_reg_arbiter_if.slave ifc
);
   logic [1:0]        state_q, state_d;
   logic              last_winner_q, last_winner_d;
   logic              bus_gnt_q, bus_gnt_d, core_gnt_q, core_gnt_d;
   logic              bus_err_q, bus_err_d, core_err_q, core_err_d;
   logic              lock_timeout_q, lock_timeout_d;
   logic [DATA_W-1:0] bus_rdata_q, bus_rdata_d, core_rdata_q, core_rdata_d;
   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];

   logic bus_elig, core_elig, grant_bus, grant_core;
   logic bus_ok, core_ok, lock_expire;

   assign bus_ok  = int'(ifc.bus_addr)  < NUM_REGS;
   assign core_ok = int'(ifc.core_addr) < NUM_REGS;

   crypto_lock_timer #(.LOCK_MAX(LOCK_MAX)) u_lock_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (state_q != ST_LOCKED),
      .enable (state_q == ST_LOCKED),
      .expire (lock_expire)
   );

   // A port already showing gnt is still holding the request just served.
   always_comb begin
      bus_elig   = ifc.bus_req  && !bus_gnt_q;
      core_elig  = ifc.core_req && !core_gnt_q;
      grant_bus  = 1'b0;
      grant_core = 1'b0;
      if (state_q == ST_LOCKED) begin
         grant_core = core_elig;
      end else if (bus_elig && core_elig) begin
         grant_bus  = (last_winner_q == PORT_CORE);
         grant_core = !grant_bus;
      end else begin
         grant_bus  = bus_elig;
         grant_core = core_elig;
      end
   end

   // NOTE: combinational logic uses blocking assignments with a default for
   // every output first, so no path leaves a value held (no latch).
   always_comb begin
      state_d        = state_q;
      lock_timeout_d = 1'b0;
      case (state_q)
         ST_IDLE:
            if (grant_core && ifc.core_lock) state_d = ST_LOCKED;
         ST_LOCKED:
            if (!ifc.core_lock) begin
               state_d = ST_IDLE;
            end else if (lock_expire) begin
               state_d        = ST_RELOCK_WAIT;
               lock_timeout_d = 1'b1;
            end
         ST_RELOCK_WAIT:
            if (!ifc.core_lock) state_d = ST_IDLE;
         default:
            state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      last_winner_d = last_winner_q;
      bus_gnt_d     = grant_bus;
      core_gnt_d    = grant_core;
      bus_err_d     = grant_bus && !bus_ok;
      core_err_d    = grant_core && !core_ok;
      bus_rdata_d   = '0;
      core_rdata_d  = '0;
      regs_d        = regs_q;
      if (grant_bus) begin
         last_winner_d = PORT_BUS;
         if (bus_ok) begin
            if (ifc.bus_we) regs_d[ifc.bus_addr] = ifc.bus_wdata;
            else            bus_rdata_d = regs_q[ifc.bus_addr];
         end
      end else if (grant_core) begin
         last_winner_d = PORT_CORE;
         if (core_ok) begin
            if (ifc.core_we) regs_d[ifc.core_addr] = ifc.core_wdata;
            else             core_rdata_d = regs_q[ifc.core_addr];
         end
      end
   end

   // NOTE: the register bank is flop-based and architecturally cleared by
   // reset, so it is reset like any other state (not inferable as RAM).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         last_winner_q  <= PORT_CORE;
         bus_gnt_q      <= 1'b0;
         core_gnt_q     <= 1'b0;
         bus_err_q      <= 1'b0;
         core_err_q     <= 1'b0;
         lock_timeout_q <= 1'b0;
         bus_rdata_q    <= '0;
         core_rdata_q   <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         state_q        <= state_d;
         last_winner_q  <= last_winner_d;
         bus_gnt_q      <= bus_gnt_d;
         core_gnt_q     <= core_gnt_d;
         bus_err_q      <= bus_err_d;
         core_err_q     <= core_err_d;
         lock_timeout_q <= lock_timeout_d;
         bus_rdata_q    <= bus_rdata_d;
         core_rdata_q   <= core_rdata_d;
         regs_q         <= regs_d;
      end
   end

   assign ifc.bus_gnt      = bus_gnt_q;
   assign ifc.bus_err      = bus_err_q;
   assign ifc.bus_rdata    = bus_rdata_q;
   assign ifc.core_gnt     = core_gnt_q;
   assign ifc.core_err     = core_err_q;
   assign ifc.core_rdata   = core_rdata_q;
   assign ifc.lock_active  = (state_q == ST_LOCKED);
   assign ifc.lock_timeout = lock_timeout_q;

endmodule

// File: tb/tb_crypto_reg_arbiter.sv
// Directed bench for crypto_reg_arbiter: handshake latency, round-robin,
// lock/release, lock timeout, illegal addresses and asynchronous reset.
module tb_crypto_reg_arbiter;
   import crypto_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   int   pulses   = 0;
   logic [15:0] exp_regs [6];

   crypto_reg_arbiter_if #(.DATA_W(16), .ADDR_W(3)) ifc ();

   crypto_reg_arbiter #(
      .DATA_W(16), .NUM_REGS(6), .ADDR_W(3), .LOCK_MAX(32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .ifc (ifc)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "bench did not finish");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_gnt(input string tag, input logic b, input logic c);
      check({tag, "_bus_gnt"}, ifc.bus_gnt, b);
      check({tag, "_core_gnt"}, ifc.core_gnt, c);
   endtask

   task automatic bus_set(input logic req, input logic we, input logic [2:0] addr,
                          input logic [15:0] wdata);
      ifc.bus_req = req; ifc.bus_we = we; ifc.bus_addr = addr; ifc.bus_wdata = wdata;
   endtask

   task automatic core_set(input logic req, input logic we, input logic [2:0] addr,
                           input logic [15:0] wdata, input logic lock);
      ifc.core_req = req; ifc.core_we = we; ifc.core_addr = addr;
      ifc.core_wdata = wdata; ifc.core_lock = lock;
   endtask

   initial begin
      exp_regs = '{16'h0000, 16'h1111, 16'hA5A5, 16'hBEEF, 16'h4444, 16'h0000};
      bus_set(0, 0, 0, 0);
      core_set(0, 0, 0, 0, 0);

      // Reset state
      step(); step();
      check_gnt("rst", 0, 0);
      check("rst_bus_err", ifc.bus_err, 0);
      check("rst_core_err", ifc.core_err, 0);
      check("rst_lock_active", ifc.lock_active, 0);
      check("rst_lock_timeout", ifc.lock_timeout, 0);
      check("rst_bus_rdata", ifc.bus_rdata, 0);
      check("rst_core_rdata", ifc.core_rdata, 0);
      rst = 1'b0;

      // 1: bus write then core read of the same register
      bus_set(1, 1, 2, 16'hA5A5);
      step();
      check_gnt("t1_wr", 1, 0);
      check("t1_wr_err", ifc.bus_err, 0);
      bus_set(0, 0, 0, 0);
      core_set(1, 0, 2, 0, 0);
      step();
      check_gnt("t1_rd", 0, 1);
      check("t1_core_rdata", ifc.core_rdata, 16'hA5A5);
      core_set(0, 0, 0, 0, 0);

      // 2: both hold read requests; grants must alternate, never together
      bus_set(1, 0, 0, 0);
      core_set(1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         check_gnt("t2_alt", (i % 2) == 0, (i % 2) == 1);
      end
      // isolated ties: last winner core -> bus, then last winner bus -> core
      bus_set(0, 0, 0, 0); core_set(0, 0, 0, 0, 0);
      step();
      bus_set(1, 0, 0, 0); core_set(1, 0, 0, 0, 0);
      step();
      check_gnt("t2_tie1", 1, 0);
      bus_set(0, 0, 0, 0); core_set(0, 0, 0, 0, 0);
      step();
      bus_set(1, 0, 0, 0); core_set(1, 0, 0, 0, 0);
      step();
      check_gnt("t2_tie2", 0, 1);
      bus_set(0, 0, 0, 0); core_set(0, 0, 0, 0, 0);
      step();

      // 3: lock with bus pending; bus served on the cycle after release
      bus_set(1, 1, 1, 16'h1111);
      step();
      check_gnt("t3_pre", 1, 0);
      bus_set(0, 0, 0, 0);
      step();
      bus_set(1, 0, 1, 0);
      core_set(1, 1, 3, 16'hBEEF, 1);
      step();
      check_gnt("t3_lock", 0, 1);
      check("t3_lock_active", ifc.lock_active, 1);
      core_set(0, 0, 0, 0, 1);
      step(); step();
      check("t3_bus_wait", ifc.bus_gnt, 0);
      check("t3_still_locked", ifc.lock_active, 1);
      core_set(0, 0, 0, 0, 0);
      step();
      check("t3_release", ifc.lock_active, 0);
      check("t3_release_bus_gnt", ifc.bus_gnt, 0);
      step();
      check("t3_bus_served", ifc.bus_gnt, 1);
      check("t3_bus_rdata", ifc.bus_rdata, 16'h1111);

      // 4: lock held past LOCK_MAX; single timeout pulse 32 cycles after entry
      bus_set(1, 0, 4, 0);
      core_set(1, 1, 4, 16'h4444, 1);
      step();
      check_gnt("t4_lock", 0, 1);
      check("t4_lock_active", ifc.lock_active, 1);
      core_set(0, 0, 0, 0, 1);
      for (int k = 1; k <= 31; k++) begin
         step();
         if (ifc.lock_timeout) pulses++;
      end
      check("t4_early_pulses", pulses, 0);
      check("t4_bus_wait", ifc.bus_gnt, 0);
      step();
      if (ifc.lock_timeout) pulses++;
      check("t4_timeout", ifc.lock_timeout, 1);
      check("t4_timeout_unlock", ifc.lock_active, 0);
      core_set(1, 0, 4, 0, 1);
      step();
      if (ifc.lock_timeout) pulses++;
      check_gnt("t4_after", 1, 0);
      check("t4_bus_rdata", ifc.bus_rdata, 16'h4444);
      bus_set(0, 0, 0, 0);
      step();
      if (ifc.lock_timeout) pulses++;
      check_gnt("t4_relock", 0, 1);
      check("t4_core_rdata", ifc.core_rdata, 16'h4444);
      check("t4_relock_ignored", ifc.lock_active, 0);
      core_set(0, 0, 0, 0, 1);
      for (int k = 35; k <= 39; k++) begin
         step();
         if (ifc.lock_timeout) pulses++;
      end
      check("t4_pulse_count", pulses, 1);
      check("t4_still_unlocked", ifc.lock_active, 0);
      core_set(0, 0, 0, 0, 0);
      step();
      core_set(1, 0, 0, 0, 1);
      step();
      check("t4_relock_ok", ifc.lock_active, 1);
      core_set(0, 0, 0, 0, 0);
      step();
      check("t4_relock_release", ifc.lock_active, 0);

      // 5: illegal addresses, then all registers keep their values
      bus_set(1, 1, 7, 16'h1234);
      step();
      check("t5_bus_gnt", ifc.bus_gnt, 1);
      check("t5_bus_err", ifc.bus_err, 1);
      check("t5_bus_rdata", ifc.bus_rdata, 0);
      bus_set(0, 0, 0, 0);
      step();
      check("t5_err_clear", ifc.bus_err, 0);
      core_set(1, 0, 6, 0, 0);
      step();
      check("t5_core_gnt", ifc.core_gnt, 1);
      check("t5_core_err", ifc.core_err, 1);
      check("t5_core_rdata", ifc.core_rdata, 0);
      core_set(0, 0, 0, 0, 0);
      step();
      for (int i = 0; i < 6; i++) begin
         bus_set(1, 0, 3'(i), 0);
         step();
         check($sformatf("t5_rd%0d_gnt", i), ifc.bus_gnt, 1);
         check($sformatf("t5_rd%0d_data", i), ifc.bus_rdata, exp_regs[i]);
         bus_set(0, 0, 0, 0);
         step();
      end

      // 6: reset while locked with bus pending
      bus_set(1, 0, 1, 0);
      core_set(1, 0, 2, 0, 1);
      step();
      check("t6_locked", ifc.lock_active, 1);
      check("t6_core_rdata_pre", ifc.core_rdata, 16'hA5A5);
      rst = 1'b1;
      #1;
      check_gnt("t6_rst", 0, 0);
      check("t6_rst_lock_active", ifc.lock_active, 0);
      check("t6_rst_core_rdata", ifc.core_rdata, 0);
      check("t6_rst_errs", {ifc.bus_err, ifc.core_err, ifc.lock_timeout}, 0);
      bus_set(0, 0, 0, 0);
      core_set(0, 0, 0, 0, 0);
      step(); step();
      check_gnt("t6_in_rst", 0, 0);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus_set(1, 0, 3'(i), 0);
         step();
         check($sformatf("t6_rd%0d_gnt", i), ifc.bus_gnt, 1);
         check($sformatf("t6_rd%0d_data", i), ifc.bus_rdata, 0);
         bus_set(0, 0, 0, 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/crypto_reg_arbiter.md
Name: crypto_reg_arbiter

Overview:
Owns the crypto core's bank of data registers and shares it between two requesters: the system bus port and the crypto core's internal datapath port.
- Single-beat read/write transfers only, handled with req/gnt handshakes and round-robin fairness.
- The core may lock the bank for multi-cycle operations, bounded by a timeout.
- Replaces ad-hoc dual-write priority with a defined, single-writer-per-cycle arbiter.

Parameters:
DATA_W, 16, width of each data register
NUM_REGS, 6, number of data registers (addresses 0..NUM_REGS-1)
ADDR_W, 3, address width; addresses >= NUM_REGS are illegal
LOCK_MAX, 32, max consecutive cycles the core may hold the lock

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
bus_req  input  1  bus transfer request, held until bus_gnt seen
bus_we  input  1  1 = write, 0 = read
bus_addr  input  ADDR_W  register address
bus_wdata  input  DATA_W  write data
bus_gnt  output  1  one-cycle grant pulse
bus_rdata  output  DATA_W  read data, valid when bus_gnt=1 and bus_we was 0
bus_err  output  1  pulses with bus_gnt on illegal address
core_req  input  1  core transfer request
core_we  input  1  1 = write
core_addr  input  ADDR_W  register address
core_wdata  input  DATA_W  write data
core_lock  input  1  request/hold exclusive ownership
core_gnt  output  1  one-cycle grant pulse
core_rdata  output  DATA_W  read data
core_err  output  1  illegal-address pulse
lock_active  output  1  bank currently locked by core
lock_timeout  output  1  one-cycle pulse on forced lock release

Behaviour:
- Reset (async, rst=1): all registers 0; all gnt/err/lock_timeout/lock_active 0; rdata 0; state IDLE; last_winner = CORE, so the bus wins the first tie.
- Handshake: requester drives req with stable we/addr/wdata until it sees gnt=1, then may drop req or present a new request.
- A port whose gnt is high in the current cycle is not eligible that cycle, which prevents double-granting the same request.
- Latency: req sampled at edge E -> gnt=1 during cycle after E.
  - Write commits at edge E.
  - Read data is registered at edge E and valid alongside gnt.
- At most one transfer per edge, so there is never a simultaneous write conflict.
- Illegal address (>= NUM_REGS): gnt and err pulse together; write dropped; rdata = 0.
- Read of a register written at the same edge returns the old value. Reads registered at E see pre-E contents.
- States: IDLE, LOCKED, RELOCK_WAIT.
- IDLE:
  - Only one eligible requester: grant it.
  - Both eligible: grant the port that is not last_winner.
  - Update last_winner on every grant.
  - If core granted with core_lock=1: go to LOCKED, lock_active=1, lock counter=0.
- LOCKED:
  - Only the core is eligible; bus_req waits (not dropped).
  - Counter increments each cycle and saturates.
  - core_lock=0 -> IDLE; lock_active=0 at next edge.
  - Counter reaches LOCK_MAX-1 with core_lock still 1 -> lock_timeout pulse, go to RELOCK_WAIT, lock_active=0. A core grant may still occur at that edge.
- RELOCK_WAIT:
  - Arbitrates like IDLE, but core_lock is ignored.
  - Returns to IDLE once core_lock=0 is sampled.
- Lock granted together with a pending bus_req: the bus is served on the first cycle after release.
- Reset mid-lock or mid-transfer: immediate return to reset state; pending transfer lost, no gnt.

Decomposition:
- Shared package crypto_pkg:
  - state enum (IDLE, LOCKED, RELOCK_WAIT)
  - port-id constants (PORT_BUS, PORT_CORE)
  - default DATA_W
- One sub-module: crypto_lock_timer.
  - Counter with clear, enable and saturating compare to LOCK_MAX-1.
  - Outputs an expire pulse.
- Arbitration, FSM and register storage stay in the top.

Test Plan:
1. Reset, bus write addr 2 = 0xA5A5, then core read addr 2 -> bus_gnt 1 cycle after req; core_gnt next; core_rdata = 0xA5A5.
2. Bus and core both request in the same cycle, repeatedly (reads, addr 0) -> grants alternate bus, core, bus, core; no cycle with both gnt high.
3. Core write with core_lock=1 while bus_req held -> lock_active=1; bus_gnt stays 0; core_lock drop -> lock_active 0 next edge; bus_gnt on the following cycle.
4. core_lock held 40 cycles, LOCK_MAX=32 -> lock_timeout pulses exactly once, 32 cycles after lock entry; bus granted next; relock ignored until core_lock low one cycle.
5. Bus write addr 7 = 0x1234 (illegal) -> bus_gnt and bus_err pulse together; subsequent reads of all 6 registers return prior values.
6. Assert rst while LOCKED with bus_req pending -> all outputs 0 immediately; registers read back 0x0000 after release.
